pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Compares the ID-stage operand demand (Tuse) against the EX/MEM producer readiness (Tnew). Also owns the multi-cycle mult/div busy sequencer.
- Drives the enable of PC and IF/ID, and the bubble-clear of ID/EX.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after issue from EX.
- DIV_CYCLES, 10, busy cycles for div/divu after issue from EX.
- CNT_W, 4, width of the busy counter; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ifReGrf1_Id  in  1  ID instruction reads rs.
- ifReGrf2_Id  in  1  ID instruction reads rt.
- grfRa1_Id  in  5  rs address in ID.
- grfRa2_Id  in  5  rt address in ID.
- tUseRs_Id  in  5  cycles until rs is consumed (0 = in ID).
- tUseRt_Id  in  5  cycles until rt is consumed.
- ifWrGrf_Ex  in  1  EX instruction writes the GRF.
- grfWa_Ex  in  5  EX destination register.
- tNew_Ex  in  5  cycles until the EX result is forwardable.
- ifWrGrf_Mem  in  1  MEM instruction writes the GRF.
- grfWa_Mem  in  5  MEM destination register.
- tNew_Mem  in  5  cycles until the MEM result is forwardable.
- mdUse_Id  in  1  ID instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- mdStart_Ex  in  1  EX instruction is mult/multu/div/divu.
- mdIsDiv_Ex  in  1  1 = div/divu, 0 = mult/multu; valid when mdStart_Ex is high.
- en_Pc  out  1  PC write enable.
- en_IfToId  out  1  IF/ID register write enable.
- clr_IdToEx  out  1  load a bubble (all-zero) into ID/EX.
- mdBusy  out  1  mult/div unit busy.
- mdDone  out  1  one-cycle pulse on the final busy cycle.
- stallCnt  out  32  saturating count of stalled cycles.

Behaviour:
- Data hazard rs (combinational): asserted when ifReGrf1_Id=1 and grfRa1_Id!=0. It additionally requires either of the following:
  - ifWrGrf_Ex=1, grfWa_Ex==grfRa1_Id and tUseRs_Id<tNew_Ex;
  - ifWrGrf_Mem=1, grfWa_Mem==grfRa1_Id and tUseRs_Id<tNew_Mem.
- Data hazard rt: identical logic using the rt signals (ifReGrf2_Id, grfRa2_Id, tUseRt_Id).
- Register $0 never causes a stall. Tuse/Tnew compare as unsigned 5-bit values.
- MD sequencer, a 2-state FSM (IDLE, BUSY) with down-counter mdCnt[CNT_W-1:0]:
  - IDLE with mdStart_Ex=1: load mdCnt = mdIsDiv_Ex ? DIV_CYCLES : MULT_CYCLES, then go to BUSY.
  - BUSY: decrement mdCnt each cycle. When mdCnt==1, assert mdDone for that cycle, set mdCnt to 0 on the next edge and return to IDLE.
  - mdStart_Ex while in BUSY is a protocol violation. It is ignored: counter not reloaded, state unchanged.
- mdBusy = (state==BUSY) | mdStart_Ex. The start cycle itself counts as busy.
- MD hazard = mdUse_Id & mdBusy.
- stall = data hazard rs | data hazard rt | MD hazard.
- Outputs: en_Pc = en_IfToId = ~stall; clr_IdToEx = stall. There is zero latency from inputs to these three outputs.
- stallCnt increments by 1 on each rising edge where stall=1 and reset=0. It saturates at 32'hFFFFFFFF.
- Reset (reset=1 at an edge): state=IDLE, mdCnt=0, stallCnt=0.
  - While reset is high, stall is forced to 0: en_Pc=1, en_IfToId=1, clr_IdToEx=0, mdBusy=0, mdDone=0.
  - Reset mid-BUSY aborts the operation. No mdDone is emitted.
- Simultaneous data and MD hazards produce a single stall. stallCnt is still counted +1 per cycle.

Test Plan:
- Load-use case. EX holds lw with ifWrGrf_Ex=1, grfWa_Ex=8, tNew_Ex=2; ID has addu reading rs=8 with tUseRs_Id=1.
  - Required: en_Pc=0, en_IfToId=0, clr_IdToEx=1, stallCnt goes 0->1.
  - Next cycle, with the lw in MEM at tNew_Mem=1: no stall.
- $0 and no-write filtering:
  - Same as the load-use case but grfRa1_Id=0 -> no stall.
  - grfWa_Ex=8 with ifWrGrf_Ex=0 -> no stall.
  - tUseRs_Id=2, tNew_Ex=2 -> no stall.
- Mult sequence:
  - Pulse mdStart_Ex=1, mdIsDiv_Ex=0 -> mdBusy high for exactly 6 cycles (the start cycle plus 5).
  - mdDone pulses on the 6th cycle.
  - mflo in ID (mdUse_Id=1) throughout -> 6 stall cycles, stallCnt=6.
- Div sequence (mdIsDiv_Ex=1) -> mdBusy for 11 cycles, mdDone on the 11th. A second mdStart_Ex at cycle 3 is ignored and mdCnt is not reloaded.
- Reset at cycle 4 of a div -> next cycle: mdBusy=0, mdDone never pulses, stallCnt=0, en_Pc=1.
- Saturation: force stallCnt near 32'hFFFFFFFE, hold stall for 3 cycles -> stallCnt ends at 32'hFFFFFFFF with no wrap.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: Tuse/Tnew data hazards, mult/div busy
// sequencing and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifReGrf1_Id,
    input  logic        ifReGrf2_Id,
    input  logic [4:0]  grfRa1_Id,
    input  logic [4:0]  grfRa2_Id,
    input  logic [4:0]  tUseRs_Id,
    input  logic [4:0]  tUseRt_Id,
    input  logic        ifWrGrf_Ex,
    input  logic [4:0]  grfWa_Ex,
    input  logic [4:0]  tNew_Ex,
    input  logic        ifWrGrf_Mem,
    input  logic [4:0]  grfWa_Mem,
    input  logic [4:0]  tNew_Mem,
    input  logic        mdUse_Id,
    input  logic        mdStart_Ex,
    input  logic        mdIsDiv_Ex,
    output logic        en_Pc,
    output logic        en_IfToId,
    output logic        clr_IdToEx,
    output logic        mdBusy,
    output logic        mdDone,
    output logic [31:0] stallCnt
);

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] mdCnt_q, mdCnt_d;
    logic [31:0]      stallCnt_q, stallCnt_d;

    logic hazRs, hazRt, hazMd;
    logic busyRaw, doneRaw, stall;

    always_comb begin
        hazRs = ifReGrf1_Id && (grfRa1_Id != 5'd0) &&
                ((ifWrGrf_Ex && (grfWa_Ex == grfRa1_Id) &&
                  (tUseRs_Id < tNew_Ex)) ||
                 (ifWrGrf_Mem && (grfWa_Mem == grfRa1_Id) &&
                  (tUseRs_Id < tNew_Mem)));
        hazRt = ifReGrf2_Id && (grfRa2_Id != 5'd0) &&
                ((ifWrGrf_Ex && (grfWa_Ex == grfRa2_Id) &&
                  (tUseRt_Id < tNew_Ex)) ||
                 (ifWrGrf_Mem && (grfWa_Mem == grfRa2_Id) &&
                  (tUseRt_Id < tNew_Mem)));
    end

    // The issue cycle already counts as busy, before the FSM has moved.
    assign busyRaw = (state_q == MD_BUSY) || mdStart_Ex;
    assign hazMd   = mdUse_Id && busyRaw;
    assign stall   = !reset && (hazRs || hazRt || hazMd);

    always_comb begin
        state_d = state_q;
        mdCnt_d = mdCnt_q;
        doneRaw = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (mdStart_Ex) begin
                    mdCnt_d = mdIsDiv_Ex ? DIV_LD : MULT_LD;
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (mdCnt_q <= CNT_ONE) begin
                    doneRaw = 1'b1;
                    mdCnt_d = '0;
                    state_d = MD_IDLE;
                end else begin
                    mdCnt_d = mdCnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = MD_IDLE;
                mdCnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stall && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MD_IDLE;
            mdCnt_q    <= '0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mdCnt_q    <= mdCnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign en_Pc      = !stall;
    assign en_IfToId  = !stall;
    assign clr_IdToEx = stall;
    assign mdBusy     = !reset && busyRaw;
    assign mdDone     = !reset && doneRaw;
    assign stallCnt   = stallCnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: data hazards, md sequencing,
// reset abort and counter saturation.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifReGrf1_Id, ifReGrf2_Id;
    logic [4:0]  grfRa1_Id, grfRa2_Id, tUseRs_Id, tUseRt_Id;
    logic        ifWrGrf_Ex;
    logic [4:0]  grfWa_Ex, tNew_Ex;
    logic        ifWrGrf_Mem;
    logic [4:0]  grfWa_Mem, tNew_Mem;
    logic        mdUse_Id, mdStart_Ex, mdIsDiv_Ex;
    logic        en_Pc, en_IfToId, clr_IdToEx, mdBusy, mdDone;
    logic [31:0] stallCnt;

    int passCnt = 0;
    int totCnt  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .ifReGrf1_Id(ifReGrf1_Id), .ifReGrf2_Id(ifReGrf2_Id),
        .grfRa1_Id(grfRa1_Id), .grfRa2_Id(grfRa2_Id),
        .tUseRs_Id(tUseRs_Id), .tUseRt_Id(tUseRt_Id),
        .ifWrGrf_Ex(ifWrGrf_Ex), .grfWa_Ex(grfWa_Ex), .tNew_Ex(tNew_Ex),
        .ifWrGrf_Mem(ifWrGrf_Mem), .grfWa_Mem(grfWa_Mem),
        .tNew_Mem(tNew_Mem),
        .mdUse_Id(mdUse_Id), .mdStart_Ex(mdStart_Ex),
        .mdIsDiv_Ex(mdIsDiv_Ex),
        .en_Pc(en_Pc), .en_IfToId(en_IfToId), .clr_IdToEx(clr_IdToEx),
        .mdBusy(mdBusy), .mdDone(mdDone), .stallCnt(stallCnt)
    );

    task automatic clear_inputs();
        ifReGrf1_Id = 0; ifReGrf2_Id = 0;
        grfRa1_Id = 0; grfRa2_Id = 0; tUseRs_Id = 0; tUseRt_Id = 0;
        ifWrGrf_Ex = 0; grfWa_Ex = 0; tNew_Ex = 0;
        ifWrGrf_Mem = 0; grfWa_Mem = 0; tNew_Mem = 0;
        mdUse_Id = 0; mdStart_Ex = 0; mdIsDiv_Ex = 0;
    endtask

    task automatic set_load_use();
        clear_inputs();
        ifWrGrf_Ex = 1; grfWa_Ex = 5'd8; tNew_Ex = 5'd2;
        ifReGrf1_Id = 1; grfRa1_Id = 5'd8; tUseRs_Id = 5'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_load_use();
        mdStart_Ex = 1; mdUse_Id = 1;
        reset = 1;
        #1;
        totCnt++;
        if ({en_Pc, en_IfToId, clr_IdToEx, mdBusy, mdDone} !== 5'b11000)
            $display("FAIL reset_outs: got %b want 11000",
                     {en_Pc, en_IfToId, clr_IdToEx, mdBusy, mdDone});
        else passCnt++;
        @(posedge clk); #1;
        totCnt++;
        if (stallCnt !== 32'd0)
            $display("FAIL reset_cnt: got %0d want 0", stallCnt);
        else passCnt++;
        @(negedge clk);
        clear_inputs();
        reset = 0;
        #1;
        totCnt++;
        if (mdBusy !== 1'b0 || en_Pc !== 1'b1)
            $display("FAIL reset_idle: busy %b enPc %b want 0 1",
                     mdBusy, en_Pc);
        else passCnt++;
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        set_load_use();
        #1;
        totCnt++;
        if ({en_Pc, en_IfToId, clr_IdToEx} !== 3'b001)
            $display("FAIL load_use_stall: got %b want 001",
                     {en_Pc, en_IfToId, clr_IdToEx});
        else passCnt++;
        @(posedge clk); #1;
        totCnt++;
        if (stallCnt !== 32'd1)
            $display("FAIL load_use_cnt: got %0d want 1", stallCnt);
        else passCnt++;
        @(negedge clk);
        ifWrGrf_Ex = 0;
        ifWrGrf_Mem = 1; grfWa_Mem = 5'd8; tNew_Mem = 5'd1;
        #1;
        totCnt++;
        if ({en_Pc, en_IfToId, clr_IdToEx} !== 3'b110)
            $display("FAIL load_use_mem: got %b want 110",
                     {en_Pc, en_IfToId, clr_IdToEx});
        else passCnt++;
        @(posedge clk); #1;
        totCnt++;
        if (stallCnt !== 32'd1)
            $display("FAIL load_use_cnt2: got %0d want 1", stallCnt);
        else passCnt++;
        @(negedge clk);
        clear_inputs();
        ifWrGrf_Mem = 1; grfWa_Mem = 5'd9; tNew_Mem = 5'd2;
        ifReGrf2_Id = 1; grfRa2_Id = 5'd9; tUseRt_Id = 5'd1;
        #1;
        totCnt++;
        if (clr_IdToEx !== 1'b1 || en_Pc !== 1'b0)
            $display("FAIL rt_mem_stall: clr %b enPc %b want 1 0",
                     clr_IdToEx, en_Pc);
        else passCnt++;
        @(posedge clk); #1;
        totCnt++;
        if (stallCnt !== 32'd2)
            $display("FAIL rt_mem_cnt: got %0d want 2", stallCnt);
        else passCnt++;
    endtask

    task automatic test_filter();
        @(negedge clk);
        set_load_use();
        grfRa1_Id = 5'd0;
        #1;
        totCnt++;
        if (en_Pc !== 1'b1)
            $display("FAIL filt_r0: enPc got %b want 1", en_Pc);
        else passCnt++;
        set_load_use();
        ifWrGrf_Ex = 0;
        #1;
        totCnt++;
        if (en_Pc !== 1'b1)
            $display("FAIL filt_nowr: enPc got %b want 1", en_Pc);
        else passCnt++;
        set_load_use();
        tUseRs_Id = 5'd2;
        #1;
        totCnt++;
        if (clr_IdToEx !== 1'b0)
            $display("FAIL filt_tuse: clr got %b want 0", clr_IdToEx);
        else passCnt++;
        set_load_use();
        ifReGrf1_Id = 0;
        #1;
        totCnt++;
        if (en_IfToId !== 1'b1)
            $display("FAIL filt_noread: en got %b want 1", en_IfToId);
        else passCnt++;
        @(posedge clk); #1;
        totCnt++;
        if (stallCnt !== 32'd2)
            $display("FAIL filt_cnt: got %0d want 2", stallCnt);
        else passCnt++;
    endtask

    task automatic test_mult();
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            mdStart_Ex = (c == 1);
            mdIsDiv_Ex = 0;
            mdUse_Id = 1;
            #1;
            totCnt++;
            if (mdBusy !== (c <= 6) || mdDone !== (c == 6) ||
                en_Pc !== (c > 6))
                $display("FAIL mult_c%0d: busy %b done %b enPc %b want %b %b %b",
                         c, mdBusy, mdDone, en_Pc,
                         (c <= 6), (c == 6), (c > 6));
            else passCnt++;
        end
        totCnt++;
        if (stallCnt !== 32'd6)
            $display("FAIL mult_cnt: got %0d want 6", stallCnt);
        else passCnt++;
    endtask

    task automatic test_div();
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            mdStart_Ex = (c == 1) || (c == 3);
            mdIsDiv_Ex = 1;
            #1;
            totCnt++;
            if (mdBusy !== (c <= 11) || mdDone !== (c == 11))
                $display("FAIL div_c%0d: busy %b done %b want %b %b",
                         c, mdBusy, mdDone, (c <= 11), (c == 11));
            else passCnt++;
        end
        totCnt++;
        if (stallCnt !== 32'd0)
            $display("FAIL div_cnt: got %0d want 0", stallCnt);
        else passCnt++;
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            mdStart_Ex = (c == 1);
            mdIsDiv_Ex = 1;
            mdUse_Id = 1;
        end
        @(posedge clk); #1;
        totCnt++;
        if (stallCnt !== 32'd3)
            $display("FAIL abort_pre_cnt: got %0d want 3", stallCnt);
        else passCnt++;
        @(negedge clk);
        reset = 1;
        #1;
        totCnt++;
        if (mdBusy !== 1'b0 || en_Pc !== 1'b1)
            $display("FAIL abort_in_rst: busy %b enPc %b want 0 1",
                     mdBusy, en_Pc);
        else passCnt++;
        @(negedge clk);
        reset = 0;
        #1;
        totCnt++;
        if (mdBusy !== 1'b0 || en_Pc !== 1'b1 || stallCnt !== 32'd0)
            $display("FAIL abort_after: busy %b enPc %b cnt %0d want 0 1 0",
                     mdBusy, en_Pc, stallCnt);
        else passCnt++;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            totCnt++;
            if (mdDone !== 1'b0 || mdBusy !== 1'b0)
                $display("FAIL abort_idle%0d: done %b busy %b want 0 0",
                         c, mdDone, mdBusy);
            else passCnt++;
        end
    endtask

    task automatic test_combined();
        do_reset();
        @(negedge clk);
        set_load_use();
        mdStart_Ex = 1; mdUse_Id = 1;
        #1;
        totCnt++;
        if (clr_IdToEx !== 1'b1 || mdBusy !== 1'b1)
            $display("FAIL comb_stall: clr %b busy %b want 1 1",
                     clr_IdToEx, mdBusy);
        else passCnt++;
        @(posedge clk); #1;
        totCnt++;
        if (stallCnt !== 32'd1)
            $display("FAIL comb_cnt: got %0d want 1", stallCnt);
        else passCnt++;
    endtask

    task automatic test_saturation();
        logic [31:0] exp [3];
        exp[0] = 32'hFFFF_FFFE;
        exp[1] = 32'hFFFF_FFFF;
        exp[2] = 32'hFFFF_FFFF;
        do_reset();
        @(negedge clk);
        dut.stallCnt_q = 32'hFFFF_FFFD;
        set_load_use();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            totCnt++;
            if (stallCnt !== exp[c])
                $display("FAIL sat_c%0d: got %h want %h", c, stallCnt, exp[c]);
            else passCnt++;
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_load_use();
        test_filter();
        test_mult();
        test_div();
        test_reset_mid_div();
        test_combined();
        test_saturation();
        $display("%0d/%0d checks passed", passCnt, totCnt);
        $finish;
    end

endmodule
